// File: rtl/tpu_pkg.sv
// Shared constants and FSM encoding for the TPU output collector.
package tpu_pkg;

  localparam int unsigned LANE_W        = 16;
  localparam int unsigned LANES         = 3;
  localparam int unsigned BYTE_W        = 8;
  localparam int signed   DEF_THRESHOLD = 2;
  localparam int unsigned DEF_DEPTH     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tpu_lane_clip.sv
// Combinational per-lane threshold/ReLU followed by unsigned 8-bit saturation.
module tpu_lane_clip
  import tpu_pkg::*;
#(
  parameter int signed THRESHOLD = DEF_THRESHOLD
) (
  input  logic signed [LANE_W-1:0] lane_i,
  output logic        [BYTE_W-1:0] byte_o,
  output logic                     sat_hi_o
);

  localparam logic signed [LANE_W-1:0] THR      = LANE_W'(THRESHOLD);
  localparam logic signed [LANE_W-1:0] BYTE_MAX = LANE_W'(255);

  always_comb begin
    byte_o   = lane_i[BYTE_W-1:0];
    sat_hi_o = 1'b0;
    if (lane_i < THR) begin
      byte_o = '0;
    end else if (lane_i > BYTE_MAX) begin
      byte_o   = '1;
      sat_hi_o = 1'b1;
    end
  end

endmodule

// File: rtl/tpu_out_collector.sv
// Result collector: lane clip, 24-bit pack, show-ahead FIFO and frame FSM.
// Optional clip statistics counter is built when TPU_OUT_STATS_EN is defined.
module tpu_out_collector
  import tpu_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 9,
  parameter int signed   THRESHOLD = DEF_THRESHOLD,
  parameter int unsigned DEPTH     = DEF_DEPTH
) (
  input  logic                       caravel_wb_clk_i,
  input  logic                       caravel_wb_rst_i,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [LANES*LANE_W-1:0]    in_data,
  output logic                       in_ready,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [LANES*BYTE_W-1:0]    rd_data,
  output logic [3:0]                 count,
  output logic                       frame_done,
  output logic                       overflow,
  output logic [15:0]                clip_cnt
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned WORD_W  = LANES * BYTE_W;
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [7:0]  FLEN    = 8'(FRAME_LEN);

  state_e            state_q, state_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]        beat_q, beat_d;
  logic              ovf_q, ovf_d;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] word;
  logic [LANES-1:0]  sat_hi;
  logic              full, empty, push, pop;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    tpu_lane_clip #(.THRESHOLD(THRESHOLD)) u_clip (
      .lane_i  (in_data[g*LANE_W +: LANE_W]),
      .byte_o  (word[g*BYTE_W +: BYTE_W]),
      .sat_hi_o(sat_hi[g])
    );
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Space check uses pre-pop occupancy: a same-cycle pop never frees a slot.
  assign in_ready   = (state_q == ST_RUN) && !full;
  assign push       = in_valid && in_ready;
  assign pop        = rd_en && !empty;
  assign rd_valid   = !empty;
  assign rd_data    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign count      = 4'(wr_ptr_q - rd_ptr_q);
  assign frame_done = (state_q == ST_DONE);
  assign overflow   = ovf_q;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    ovf_d    = ovf_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          beat_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (push) begin
          beat_d = beat_q + 8'd1;
          if (beat_d == FLEN) state_d = ST_DONE;
        end else if (in_valid) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge caravel_wb_clk_i) begin
    if (caravel_wb_rst_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      beat_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge caravel_wb_clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= word;
  end

`ifdef TPU_OUT_STATS_EN
  localparam int unsigned NW = $clog2(LANES + 1);

  logic [15:0]   clip_q, clip_d;
  logic [NW-1:0] nsat;
  logic [16:0]   clip_sum;

  always_comb begin
    nsat = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      nsat = nsat + NW'(sat_hi[i]);
    end
    clip_sum = {1'b0, clip_q} + 17'(nsat);
    clip_d   = clip_q;
    if (start && (state_q != ST_RUN)) begin
      clip_d = '0;
    end else if (push) begin
      clip_d = clip_sum[16] ? '1 : clip_sum[15:0];
    end
  end

  always_ff @(posedge caravel_wb_clk_i) begin
    if (caravel_wb_rst_i) clip_q <= '0;
    else                  clip_q <= clip_d;
  end

  assign clip_cnt = clip_q;
`else
  logic unused_sat;
  assign unused_sat = ^sat_hi;
  assign clip_cnt   = '0;
`endif

endmodule

// File: tb/tb_tpu_out_collector.sv
// Self-checking bench for tpu_out_collector against a queue-based reference model.
module tb_tpu_out_collector;

  localparam int FRAME_LEN = 9;
  localparam int THR       = 2;
  localparam int DEPTH     = 8;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, rd_en;
  logic [47:0] in_data;
  logic        in_ready, rd_valid, frame_done, overflow;
  logic [23:0] rd_data;
  logic [3:0]  count;
  logic [15:0] clip_cnt;

  int errors = 0;
  int checks = 0;

  logic [23:0] q[$];
  bit m_run, m_done, m_ovf;
  int m_beats, m_clip;

  always #5 clk = ~clk;

  tpu_out_collector #(
    .FRAME_LEN(FRAME_LEN),
    .THRESHOLD(THR),
    .DEPTH    (DEPTH)
  ) dut (
    .caravel_wb_clk_i(clk),
    .caravel_wb_rst_i(rst),
    .start           (start),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .rd_en           (rd_en),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .count           (count),
    .frame_done      (frame_done),
    .overflow        (overflow),
    .clip_cnt        (clip_cnt)
  );

  function automatic logic [7:0] lane_ref(input logic [15:0] raw);
    int v = int'($signed(raw));
    if (v < THR) return 8'h00;
    if (v > 255) return 8'hFF;
    return v[7:0];
  endfunction

  function automatic logic [23:0] pack_ref(input logic [47:0] d);
    return {lane_ref(d[47:32]), lane_ref(d[31:16]), lane_ref(d[15:0])};
  endfunction

  function automatic int sat_lanes(input logic [47:0] d);
    int n = 0;
    for (int k = 0; k < 3; k++) begin
      logic [15:0] l = d[k*16 +: 16];
      if (int'($signed(l)) > 255) n++;
    end
    return n;
  endfunction

  function automatic logic [15:0] rand_lane();
    case ($urandom_range(0, 5))
      0: return 16'($urandom_range(0, 3));
      1: return 16'($urandom_range(254, 257));
      2: return 16'h8000;
      3: return 16'hFFFF;
      4: return 16'($urandom_range(0, 255));
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [47:0] rand_beat();
    return {rand_lane(), rand_lane(), rand_lane()};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_run = 0; m_done = 0; m_ovf = 0; m_beats = 0; m_clip = 0;
  endtask

  // One clock: drive, check pre-edge outputs against the model, advance model.
  task automatic cyc(input logic r, input logic s, input logic v,
                     input logic [47:0] d, input logic re);
    bit exp_ready, was_run;
    rst = r; start = s; in_valid = v; in_data = d; rd_en = re;
    #1;
    exp_ready = m_run && (q.size() < DEPTH);
    check("in_ready",   in_ready,   exp_ready);
    check("rd_valid",   rd_valid,   q.size() != 0);
    check("rd_data",    rd_data,    (q.size() != 0) ? q[0] : 24'h0);
    check("count",      count,      q.size());
    check("frame_done", frame_done, m_done);
    check("overflow",   overflow,   m_ovf);
    check("clip_cnt",   clip_cnt,   m_clip);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      was_run = m_run;
      if (re && q.size() > 0) void'(q.pop_front());
      if (v && exp_ready) begin
        q.push_back(pack_ref(d));
        m_beats++;
`ifdef TPU_OUT_STATS_EN
        m_clip = m_clip + sat_lanes(d);
        if (m_clip > 65535) m_clip = 65535;
`endif
        if (m_beats == FRAME_LEN) begin
          m_run = 0; m_done = 1;
        end
      end else if (v && was_run) begin
        m_ovf = 1;
      end
      if (s && !was_run) begin
        m_run = 1; m_done = 0; m_beats = 0; m_ovf = 0; m_clip = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; rd_en = 1'b0;
    in_data = 48'h0100_0100_0100;
    @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset values with in_valid held high; nothing is written before start.
    cyc(1, 0, 1, 48'h0100_0100_0100, 0);
    repeat (3) cyc(0, 0, 1, 48'h0100_0100_0100, 0);
    check("idle_no_write", count, 0);

    cyc(0, 1, 0, 48'h0, 0);
    cyc(0, 0, 1, 48'h0100_0001_0050, 0);
    check("pack_sat", rd_data, 24'hFF0050);
`ifdef TPU_OUT_STATS_EN
    check("clip_one", clip_cnt, 1);
`else
    check("clip_off", clip_cnt, 0);
`endif
    cyc(0, 0, 1, 48'h8000_0002_FFFF, 1);
    check("pack_neg", rd_data, 24'h000200);

    // Nine beats in total complete the frame and fill the FIFO.
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, rand_beat(), 0);
    check("done_rise", frame_done, 1);
    check("full_count", count, 8);
    cyc(0, 0, 1, rand_beat(), 0);
    check("done_ignore", count, 8);
    check("done_no_ovf", overflow, 0);
    cyc(0, 1, 0, 48'h0, 0);
    check("done_fall", frame_done, 0);

    // Full in RUN: push with pop drops the beat but still pops.
    cyc(0, 0, 1, rand_beat(), 1);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 7);

    repeat (7) cyc(0, 0, 0, 48'h0, 1);
    check("drained", rd_valid, 0);

    // Streaming with reads held: order across wrap, re-arming between frames.
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 1, rand_beat(), 1);
      check("stream_count_le1", count <= 4'd1, 1);
    end
    check("stream_no_ovf", overflow, 0);

    // Reset in the middle of a frame discards contents.
    cyc(0, 1, 0, 48'h0, 0);
    repeat (4) cyc(0, 0, 1, rand_beat(), 0);
    cyc(1, 0, 1, rand_beat(), 0);
    check("midreset_count", count, 0);
    check("midreset_valid", rd_valid, 0);

    for (int i = 0; i < 400; i++) begin
      logic r, s, v, re;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 7) == 0);
      v  = ($urandom_range(0, 3) != 0);
      re = ($urandom_range(0, 2) == 0);
      cyc(r, s, v, rand_beat(), re);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tpu_out_collector.md
# tpu_out_collector

Downstream stage of the systolic array. Consumes 48-bit result beats (three signed 16-bit lanes) and applies a threshold/ReLU plus unsigned 8-bit saturation to each lane. Packs each beat into one 24-bit word and buffers it in an 8-entry FIFO. The Wishbone slave drains the FIFO through `rd_data`. A small frame FSM counts accepted beats and flags completion of a programmed result frame.

## Interface
Parameters:
- `FRAME_LEN`, 9: accepted beats per frame, range 1..255.
- `THRESHOLD`, 2: signed lane threshold; lanes below it become 0.
- `DEPTH`, 8: FIFO entries, power of two.

Ports:
- `caravel_wb_clk_i`  in  1  single clock.
- `caravel_wb_rst_i`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that arms a frame.
- `in_valid`  in  1  result beat present.
- `in_data`  in  48  lane0 = [15:0], lane1 = [31:16], lane2 = [47:32], signed.
- `in_ready`  out  1  beat will be accepted this cycle.
- `rd_en`  in  1  pop the head word.
- `rd_valid`  out  1  FIFO not empty.
- `rd_data`  out  24  head word: byte k = processed lane k.
- `count`  out  4  FIFO occupancy, 0..8.
- `frame_done`  out  1  level signal; high in DONE.
- `overflow`  out  1  sticky; a beat was dropped.
- `clip_cnt`  out  16  lanes clipped high (see Configuration).

## Operation
- FSM states:
  - IDLE to RUN on `start`; clears the beat counter and `overflow`.
  - RUN to DONE on the edge that accepts beat number `FRAME_LEN`; `start` is ignored in RUN.
  - DONE to RUN on `start`, clearing the counter and `overflow`.
- `in_ready = (state==RUN) & (count<DEPTH)`, where `count` is the value before any same-cycle pop. A pop does not free space for a push in the same cycle.
- Accept occurs when `in_valid & in_ready`: the packed word is written at `wr_ptr` and the beat counter increments.
- The upstream array cannot stall. `in_valid & ~in_ready` while in RUN drops the beat and sets `overflow`; the dropped beat is not counted. `in_valid` outside RUN is ignored silently.
- Lane processing, signed compare on the full 16 bits:
  - lane < `THRESHOLD` gives 0x00.
  - lane > 255 gives 0xFF.
  - otherwise the result is lane[7:0].
- `rd_data` is show-ahead: the combinational read of `mem[rd_ptr]`. `rd_data` is 0 when empty.
- Pop occurs when `rd_en & rd_valid`. `rd_en` while empty is ignored: no pointer change and no error.
- Simultaneous push and pop when 0 < `count` < 8: `count` is unchanged.
- Pointers are log2(DEPTH)+1 bits wide and wrap naturally. Full is defined as MSBs differ and LSBs equal.
- `start` does not flush the FIFO. Only reset empties it.

## Timing
- Reset values:
  - `in_ready` = 0, `rd_valid` = 0, `rd_data` = 0, `count` = 0.
  - `frame_done` = 0, `overflow` = 0, `clip_cnt` = 0.
  - state = IDLE, pointers = 0.
- Write to read latency: a word accepted on edge N has `rd_valid` = 1 after edge N.
- `frame_done` rises on the edge after the final accept and falls on the edge after `start`.
- `overflow` updates on the edge following the dropped beat.
- Reset asserted mid-frame: everything returns to reset values on the next edge, and FIFO contents are discarded.

## Configuration
- Macro: `TPU_OUT_STATS_EN`.
- Defined:
  - `clip_cnt` increments by the number of lanes (0..3) saturated to 0xFF in each accepted beat.
  - It saturates at 0xFFFF.
  - It is cleared by reset and by `start`.
- Undefined: `clip_cnt` is tied to 0 and no counter logic is built. The port remains present.

## Structure
- Shared package `tpu_pkg`:
  - lane width 16, lanes 3, byte width 8.
  - default `THRESHOLD` 2 and `DEPTH` 8.
  - FSM state encoding: IDLE = 0, RUN = 1, DONE = 2.
- Sub-module `tpu_lane_clip`: one instance per lane. It is purely combinational: 16-bit signed in, 8-bit out, plus a `sat_hi` flag.
- FIFO storage, pointers and FSM live in the top level.

## Test plan
- Reset with `in_valid` = 1 held: `in_ready` = 0, `count` = 0, and no write occurs until `start`.
- `start`, then one beat with lanes {lane2 = 0x0100, lane1 = 0x0001, lane0 = 0x0050} → `rd_data` = 0xFF0050 one cycle later. With `TPU_OUT_STATS_EN`, `clip_cnt` = 1.
- Negative and threshold lanes {0x8000, 0x0002, 0xFFFF} → `rd_data` = 0x000200.
- `FRAME_LEN` = 9 with 9 continuous beats → `frame_done` = 1 after the 9th accept. A 10th beat is ignored and `count` stays 8. Then `start` → `frame_done` = 0.
- Fill to 8 with no reads, then `in_valid` with `rd_en` in the same cycle → beat dropped, `overflow` = 1, `count` = 7, and the head advances.
- 20 beats with `rd_en` held high and `FRAME_LEN` = 20 → FIFO order preserved across pointer wrap, `count` ≤ 1, `overflow` = 0.
